// File: rtl/decode_stage_hz_if.sv
// rtl/decode_stage_hz_if.sv - fetch, writeback and ID/EX signal bundle for decode_stage_hz
interface decode_stage_hz_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            valid_D;
    logic [31:0]     instruction_D;
    logic [XLEN-1:0] PC_D;
    logic            flush_D;
    logic            stall_D;

    logic            wEn;
    logic [RA_W-1:0] write_reg;
    logic [XLEN-1:0] write_data;

    logic            valid_E;
    logic            ALUsrcE;
    logic            memToRegE;
    logic            regWriteE;
    logic            memReadE;
    logic            memWriteE;
    logic            branchE;
    logic [1:0]      ALUopE;
    logic [RA_W-1:0] write_regE;
    logic [RA_W-1:0] read_regE1;
    logic [RA_W-1:0] read_regE2;
    logic [XLEN-1:0] read_dataE1;
    logic [XLEN-1:0] read_dataE2;
    logic [XLEN-1:0] PC_E;
    logic [XLEN-1:0] GenOutE;

    modport master (
        output valid_D, instruction_D, PC_D, flush_D, wEn, write_reg, write_data,
        input  stall_D, valid_E, ALUsrcE, memToRegE, regWriteE, memReadE, memWriteE,
               branchE, ALUopE, write_regE, read_regE1, read_regE2, read_dataE1,
               read_dataE2, PC_E, GenOutE
    );

    modport slave (
        input  valid_D, instruction_D, PC_D, flush_D, wEn, write_reg, write_data,
        output stall_D, valid_E, ALUsrcE, memToRegE, regWriteE, memReadE, memWriteE,
               branchE, ALUopE, write_regE, read_regE1, read_regE2, read_dataE1,
               read_dataE2, PC_E, GenOutE
    );
endinterface

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - decode stage with register file, hazard detection and ID/EX register
module decode_stage_hz #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic             clock,
    input logic             reset,
    decode_stage_hz_if.slave bus
);
    localparam int         DEPTH     = 2 ** RA_W;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;

    assign inst   = bus.instruction_D;
    assign opcode = inst[6:0];
    assign rs1    = RA_W'(inst[19:15]);
    assign rs2    = RA_W'(inst[24:20]);
    assign rd     = RA_W'(inst[11:7]);

    logic            aluSrc;
    logic            memToReg;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic [1:0]      aluOp;
    logic            usesRs2;
    logic [XLEN-1:0] imm;

    always_comb begin
        aluSrc   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        branch   = 1'b0;
        aluOp    = 2'b00;
        usesRs2  = 1'b0;
        imm      = '0;
        case (opcode)
            OP_R: begin
                regWrite = 1'b1;
                aluOp    = 2'b10;
                usesRs2  = 1'b1;
            end
            OP_I: begin
                aluSrc   = 1'b1;
                regWrite = 1'b1;
                aluOp    = 2'b11;
                imm      = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OP_LOAD: begin
                aluSrc   = 1'b1;
                memToReg = 1'b1;
                regWrite = 1'b1;
                memRead  = 1'b1;
                imm      = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                aluSrc   = 1'b1;
                memWrite = 1'b1;
                usesRs2  = 1'b1;
                imm      = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                aluOp    = 2'b01;
                usesRs2  = 1'b1;
                imm      = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] regs [DEPTH];
    logic            wbActive;

    assign wbActive = bus.wEn && (bus.write_reg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wbActive) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    // Writeback data is forwarded so a same-cycle reader never sees the stale value.
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    assign rdata1 = (rs1 == '0) ? '0 :
                    (wbActive && bus.write_reg == rs1) ? bus.write_data : regs[rs1];
    assign rdata2 = (rs2 == '0) ? '0 :
                    (wbActive && bus.write_reg == rs2) ? bus.write_data : regs[rs2];

    logic loadUse;
    logic bubble;

    assign loadUse = bus.valid_E && bus.memReadE && (bus.write_regE != '0) && bus.valid_D &&
                     ((bus.write_regE == rs1) || ((bus.write_regE == rs2) && usesRs2));
    assign bus.stall_D = loadUse;
    assign bubble      = bus.flush_D || loadUse || !bus.valid_D;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.valid_E     <= 1'b0;
            bus.ALUsrcE     <= 1'b0;
            bus.memToRegE   <= 1'b0;
            bus.regWriteE   <= 1'b0;
            bus.memReadE    <= 1'b0;
            bus.memWriteE   <= 1'b0;
            bus.branchE     <= 1'b0;
            bus.ALUopE      <= 2'b00;
            bus.write_regE  <= '0;
            bus.read_regE1  <= '0;
            bus.read_regE2  <= '0;
            bus.read_dataE1 <= '0;
            bus.read_dataE2 <= '0;
            bus.PC_E        <= '0;
            bus.GenOutE     <= '0;
        end else begin
            bus.valid_E     <= !bubble;
            bus.ALUsrcE     <= aluSrc   && !bubble;
            bus.memToRegE   <= memToReg && !bubble;
            bus.regWriteE   <= regWrite && !bubble;
            bus.memReadE    <= memRead  && !bubble;
            bus.memWriteE   <= memWrite && !bubble;
            bus.branchE     <= branch   && !bubble;
            bus.ALUopE      <= bubble ? 2'b00 : aluOp;
            bus.write_regE  <= rd;
            bus.read_regE1  <= rs1;
            bus.read_regE2  <= rs2;
            bus.read_dataE1 <= rdata1;
            bus.read_dataE2 <= rdata2;
            bus.PC_E        <= bus.PC_D;
            bus.GenOutE     <= imm;
        end
    end
endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - directed and randomized bench for decode_stage_hz
module tb_decode_stage_hz;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    decode_stage_hz_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();
    decode_stage_hz #(.XLEN(XLEN), .RA_W(RA_W)) dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] mRegs [32];
    logic            eValid;
    logic [7:0]      eCtrl;
    logic [4:0]      eRd, eRs1, eRs2;
    logic [XLEN-1:0] eD1, eD2, ePc, eImm;
    logic            obsStall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ALUsrc, memToReg, regWrite, memRead, memWrite, branch, ALUop}
    function automatic logic [7:0] refCtrl(input logic [6:0] op);
        case (op)
            OP_R:      return 8'b0_0_1_0_0_0_10;
            OP_I:      return 8'b1_0_1_0_0_0_11;
            OP_LOAD:   return 8'b1_1_1_1_0_0_00;
            OP_STORE:  return 8'b1_0_0_0_1_0_00;
            OP_BRANCH: return 8'b0_0_0_0_0_1_01;
            default:   return 8'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] refImm(input logic [31:0] i);
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        i12 = i[31:20];
        s12 = {i[31:25], i[11:7]};
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        case (i[6:0])
            OP_I, OP_LOAD: return XLEN'(i12);
            OP_STORE:      return XLEN'(s12);
            OP_BRANCH:     return XLEN'(b13);
            default:       return '0;
        endcase
    endfunction

    function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
    endfunction

    function automatic logic [31:0] encI(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm12);
        return {imm12, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm12);
        return {imm12[11:5], rs2, rs1, 3'b010, imm12[4:0], OP_STORE};
    endfunction

    task automatic checkE();
        chk("valid_E", 64'(bus.valid_E), 64'(eValid));
        chk("ctrlE", 64'({bus.ALUsrcE, bus.memToRegE, bus.regWriteE, bus.memReadE,
                          bus.memWriteE, bus.branchE, bus.ALUopE}), 64'(eCtrl));
        chk("write_regE", 64'(bus.write_regE), 64'(eRd));
        chk("read_regE1", 64'(bus.read_regE1), 64'(eRs1));
        chk("read_regE2", 64'(bus.read_regE2), 64'(eRs2));
        chk("read_dataE1", 64'(bus.read_dataE1), 64'(eD1));
        chk("read_dataE2", 64'(bus.read_dataE2), 64'(eD2));
        chk("PC_E", 64'(bus.PC_E), 64'(ePc));
        chk("GenOutE", 64'(bus.GenOutE), 64'(eImm));
    endtask

    function automatic logic [XLEN-1:0] refRead(input logic [4:0] a, input logic we,
                                                input logic [4:0] wr, input logic [XLEN-1:0] wd);
        if (a == 5'd0) return '0;
        if (we && wr == a) return wd;
        return mRegs[a];
    endfunction

    // Drives one decode cycle away from the edge, checks stall, then checks ID/EX after the edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] pc, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [XLEN-1:0] wd);
        logic [6:0]      op;
        logic [4:0]      rs1, rs2, rd;
        logic            needRs2, expStall, bub;
        logic [XLEN-1:0] d1, d2;
        bus.valid_D       = v;
        bus.instruction_D = inst;
        bus.PC_D          = pc;
        bus.flush_D       = fl;
        bus.wEn           = we;
        bus.write_reg     = wr;
        bus.write_data    = wd;
        op  = inst[6:0];
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        rd  = inst[11:7];
        needRs2  = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
        expStall = eValid && eCtrl[4] && (eRd != 5'd0) && v && ((eRd == rs1) || (needRs2 && eRd == rs2));
        #1;
        obsStall = bus.stall_D;
        chk("stall_D", 64'(obsStall), 64'(expStall));
        d1  = refRead(rs1, we, wr, wd);
        d2  = refRead(rs2, we, wr, wd);
        bub = fl || expStall || !v;
        @(posedge clock);
        if (we && wr != 5'd0) mRegs[wr] = wd;
        eValid = !bub;
        eCtrl  = bub ? 8'b0 : refCtrl(op);
        eRd    = rd;
        eRs1   = rs1;
        eRs2   = rs2;
        eD1    = d1;
        eD2    = d2;
        ePc    = pc;
        eImm   = refImm(inst);
        #1;
        checkE();
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        eValid = 1'b0; eCtrl = '0; eRd = '0; eRs1 = '0; eRs2 = '0;
        eD1 = '0; eD2 = '0; ePc = '0; eImm = '0;
    endtask

    initial begin
        logic [31:0] inst;
        logic [6:0]  ops [6];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD;
        ops[3] = OP_STORE; ops[4] = OP_BRANCH; ops[5] = OP_LUI;

        bus.valid_D = 1'b0; bus.instruction_D = '0; bus.PC_D = '0; bus.flush_D = 1'b0;
        bus.wEn = 1'b0; bus.write_reg = '0; bus.write_data = '0;
        clearModel();
        #3;
        checkE();
        chk("reset stall_D", 64'(bus.stall_D), 64'(0));
        @(negedge clock); @(negedge clock);
        #1 reset = 1'b1;

        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd7);
        step(1'b1, encR(5'd3, 5'd1, 5'd2), 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("add regWriteE", 64'(bus.regWriteE), 64'(1));
        chk("add ALUopE", 64'(bus.ALUopE), 64'(2));
        chk("add read_dataE1", 64'(bus.read_dataE1), 64'(5));
        chk("add read_dataE2", 64'(bus.read_dataE2), 64'(7));
        chk("add write_regE", 64'(bus.write_regE), 64'(3));
        chk("add valid_E", 64'(bus.valid_E), 64'(1));

        step(1'b1, encI(OP_LOAD, 5'd4, 5'd1, 12'hFF8), 32'h104, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lw GenOutE", 64'(bus.GenOutE), 64'(32'hFFFF_FFF8));
        chk("lw memReadE", 64'(bus.memReadE), 64'(1));
        chk("lw memToRegE", 64'(bus.memToRegE), 64'(1));
        chk("lw ALUsrcE", 64'(bus.ALUsrcE), 64'(1));

        step(1'b1, encI(OP_LOAD, 5'd4, 5'd1, 12'h000), 32'h108, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, encR(5'd5, 5'd4, 5'd2), 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("loaduse stall", 64'(obsStall), 64'(1));
        chk("loaduse bubble valid", 64'(bus.valid_E), 64'(0));
        chk("loaduse bubble regWrite", 64'(bus.regWriteE), 64'(0));
        step(1'b1, encR(5'd5, 5'd4, 5'd2), 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("reissue stall", 64'(obsStall), 64'(0));
        chk("reissue valid", 64'(bus.valid_E), 64'(1));

        step(1'b1, encI(OP_LOAD, 5'd4, 5'd1, 12'h000), 32'h110, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, encI(OP_I, 5'd5, 5'd6, 12'h001), 32'h114, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi no stall", 64'(obsStall), 64'(0));
        chk("addi valid", 64'(bus.valid_E), 64'(1));

        step(1'b1, encR(5'd7, 5'd0, 5'd2), 32'h118, 1'b0, 1'b1, 5'd2, 32'hDEAD);
        chk("bypass read_dataE2", 64'(bus.read_dataE2), 64'(32'hDEAD));
        step(1'b1, encR(5'd7, 5'd1, 5'd0), 32'h11C, 1'b0, 1'b1, 5'd0, 32'hBEEF);
        chk("x0 read_dataE2", 64'(bus.read_dataE2), 64'(0));

        step(1'b1, encS(5'd1, 5'd2, 12'h004), 32'h120, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush valid", 64'(bus.valid_E), 64'(0));
        chk("flush memWriteE", 64'(bus.memWriteE), 64'(0));
        step(1'b1, encI(OP_LOAD, 5'd4, 5'd1, 12'h000), 32'h124, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, encR(5'd5, 5'd4, 5'd2), 32'h128, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush+stall stall", 64'(obsStall), 64'(1));
        chk("flush+stall valid", 64'(bus.valid_E), 64'(0));

        step(1'b1, encI(OP_LOAD, 5'd4, 5'd1, 12'h000), 32'h12C, 1'b0, 1'b1, 5'd5, 32'h55);
        #2 reset = 1'b0;
        #1;
        clearModel();
        checkE();
        chk("async reset stall_D", 64'(bus.stall_D), 64'(0));
        @(negedge clock);
        #1 reset = 1'b1;
        step(1'b1, encR(5'd6, 5'd5, 5'd0), 32'h130, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("x5 after reset", 64'(bus.read_dataE1), 64'(0));

        for (int n = 0; n < 400; n++) begin
            inst         = $urandom;
            inst[6:0]    = ops[$urandom_range(0, 5)];
            inst[11:7]   = 5'($urandom_range(0, 7));
            inst[19:15]  = 5'($urandom_range(0, 7));
            inst[24:20]  = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 9) != 0), inst, XLEN'($urandom), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), XLEN'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage with an integrated ID/EX pipeline register, register file, immediate generator and main controller, plus load-use hazard detection, bubble insertion, flush, and WB-to-ID write-through bypass. It sits between the IF/ID register (fetch side) and the execute stage of the 5-stage RISC-V pipeline, replacing the fixed 32-bit decode stage. All `*_E` outputs are registered; `stall_D` is combinational toward fetch.

## Interface
- XLEN, 32, datapath width for register data, PC and immediates (≥32)
- RA_W, 5, register address width; register file depth 2^RA_W; x0 hard-wired to 0
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears register file and ID/EX register
- valid_D  in  1  instruction_D holds a real instruction
- instruction_D  in  32  instruction from IF/ID
- PC_D  in  XLEN  PC of instruction_D
- flush_D  in  1  branch-resolved redirect; squash the instruction being decoded
- wEn  in  1  writeback enable
- write_reg  in  RA_W  writeback destination
- write_data  in  XLEN  writeback data
- stall_D  out  1  load-use hazard; fetch must hold PC and IF/ID
- valid_E, ALUsrcE, memToRegE, regWriteE, memReadE, memWriteE, branchE  out  1 each  registered controls
- ALUopE  out  2  registered ALU op class
- write_regE, read_regE1, read_regE2  out  RA_W  registered rd, rs1, rs2
- read_dataE1, read_dataE2, PC_E, GenOutE  out  XLEN  registered operands, PC, immediate

## Operation
- Decode (opcode = instruction_D[6:0]); {ALUsrc,memToReg,regWrite,memRead,memWrite,branch,ALUop}:
  - 0110011 R: 0,0,1,0,0,0,10
  - 0010011 I-ALU: 1,0,1,0,0,0,11
  - 0000011 load: 1,1,1,1,0,0,00
  - 0100011 store: 1,0,0,0,1,0,00
  - 1100011 branch: 0,0,0,0,0,1,01
  - any other opcode: all 0
- Immediate, sign-extended from inst[31] to XLEN: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; R and unknown opcodes give 0.
- Register addresses are rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7], zero-extended or truncated to RA_W.
- Register file:
  - Two asynchronous read ports and one write port, written on the rising edge when wEn=1 and write_reg≠0.
  - Reads of x0 return 0.
  - Bypass: if wEn=1, write_reg≠0 and write_reg equals a read address, that port returns write_data in the same cycle.
- Hazard: `stall_D = valid_E & memReadE & (write_regE≠0) & valid_D & (write_regE==rs1 | (write_regE==rs2 & opcode∈{R, store, branch}))`.
- ID/EX update each clock edge, in priority order:
  1. flush_D=1 → bubble.
  2. stall_D=1 → bubble; the instruction is re-presented next cycle by fetch.
  3. valid_D=0 → bubble.
  4. Otherwise load the decoded values with valid_E=1.
- Bubble: valid_E and all seven control bits = 0; data and address fields load the current decode values and are don't-care.

## Timing
- Reset (reset=0, async): all ID/EX outputs = 0 immediately; all registers x1..x(2^RA_W−1) = 0. stall_D = 0 while in reset, because valid_E = 0.
- Latency: instruction_D valid in cycle n → `*_E` valid in cycle n+1.
- A WB write and a read of the same register in the same cycle returns the new data via the bypass. The write itself commits on the edge.
- Stall: held for exactly one cycle per load-use pair. In the next cycle valid_E=0, so stall_D drops and the dependent instruction issues.
- flush_D together with stall_D: flush wins, and stall_D is still driven for that cycle.
- Reset deasserted mid-operation: the first edge after release captures normally; there is no partial state.

## Test plan
- Reset: assert reset=0 asynchronously mid-cycle → all `*_E`=0 immediately; after release, reading x5 returns 0.
- Decode: R-type `add x3,x1,x2` with x1=5, x2=7 → next edge: regWriteE=1, ALUopE=10, read_dataE1=5, read_dataE2=7, write_regE=3, valid_E=1.
- Immediate: `lw x4,-8(x1)` → GenOutE=0xFFFFFFF8, memReadE=1, memToRegE=1, ALUsrcE=1. With XLEN=64: GenOutE=0xFFFFFFFFFFFFFFF8.
- Load-use: `lw x4,0(x1)` followed by `add x5,x4,x2` → stall_D=1 for one cycle and a bubble (valid_E=0, regWriteE=0); the add issues on the next cycle. Repeat with `addi x5,x6,1` → no stall.
- Bypass: wEn=1, write_reg=2, write_data=0xDEAD, with an instruction reading x2 in the same cycle → read_dataE2=0xDEAD. With write_reg=0 → the x0 read stays 0.
- Flush: flush_D=1 with a valid store in decode → valid_E=0, memWriteE=0. With flush_D and stall_D both set → bubble.
